// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg
// Shared types and constants for the SHA-256 message-schedule datapath.
//   word_t          : 32-bit schedule word
//   S0_* / S1_*     : rotate/shift amounts of the small-sigma functions
//                     sigma0 = ROTR7 ^ ROTR18 ^ SHR3
//                     sigma1 = ROTR17 ^ ROTR19 ^ SHR10
//   SHA256_ROUNDS   : schedule length of a full SHA-256 block
//   state_t         : schedule expander control states
//   bswap32         : byte reversal used for little-endian sources
// ----------------------------------------------------------------------------
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int SHA256_ROUNDS = 64;

    localparam int S0_R1 = 7;
    localparam int S0_R2 = 18;
    localparam int S0_S  = 3;

    localparam int S1_R1 = 17;
    localparam int S1_R2 = 19;
    localparam int S1_S  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic word_t bswap32(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// ----------------------------------------------------------------------------
// sha256_small_sigma
// Purely combinational SHA-256 small-sigma function:
//   y = ROTR(x, R1) ^ ROTR(x, R2) ^ SHR(x, S)
// Left unregistered on purpose so the schedule window can compute and shift
// in a new word within a single clock.
// Parameters: R1, R2 (rotate amounts, 1..31), S (shift amount, 0..31)
// Ports:
//   x  in  32  input word
//   y  out 32  sigma(x)
// ----------------------------------------------------------------------------
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int R1 = 7,
    parameter int R2 = 18,
    parameter int S  = 3
) (
    input  word_t x,
    output word_t y
);

    word_t rot1;
    word_t rot2;
    word_t shr;

    assign rot1 = (x >> R1) | (x << (32 - R1));
    assign rot2 = (x >> R2) | (x << (32 - R2));
    assign shr  = x >> S;

    assign y = rot1 ^ rot2 ^ shr;

endmodule

// File: rtl/sha256_msg_schedule.sv
// ----------------------------------------------------------------------------
// sha256_msg_schedule
// SHA-256 message-schedule expander. Accepts one 512-bit padded block and
// emits W[0]..W[ROUNDS-1], one 32-bit word per w_valid/w_ready handshake,
// using a 16-word sliding window with on-the-fly expansion:
//   W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]  (mod 2^32)
//
// Build option: define SHA_SCHED_BYTESWAP_EN to byte-reverse every input
// word on load (little-endian memory sources). Without it words load as-is.
//
// Parameters:
//   ROUNDS  words emitted per block, 16..64
//   IDX_W   width of w_idx, 2**IDX_W >= ROUNDS
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   blk_valid  in   1       block_in is valid
//   blk_ready  out  1       block accepted on blk_valid && blk_ready
//   block_in   in   512     word 0 = [511:480], word 15 = [31:0]
//   w_valid    out  1       w_out holds a valid schedule word
//   w_ready    in   1       downstream accepts w_out
//   w_out      out  32      schedule word W[w_idx]
//   w_idx      out  IDX_W   index of w_out
//   done       out  1       one-cycle pulse after the final word is taken
// ----------------------------------------------------------------------------
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     block_in,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_out,
    output logic [IDX_W-1:0] w_idx,
    output logic             done
);

    generate
        if (ROUNDS < 16 || ROUNDS > 64 || (2 ** IDX_W) < ROUNDS) begin : g_bad_cfg
            $error("sha256_msg_schedule: illegal ROUNDS/IDX_W combination");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t           state_reg, state_next;
    word_t            win_reg  [16];
    word_t            win_next [16];
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             done_reg, done_next;

    word_t            load_word [16];
    word_t            s0;
    word_t            s1;
    word_t            new_word;
    logic             accept;
    logic             step;

    // Slice the block into words; word 0 sits in the most significant lane.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_load
`ifdef SHA_SCHED_BYTESWAP_EN
            assign load_word[gi] = bswap32(block_in[511-32*gi -: 32]);
`else
            assign load_word[gi] = block_in[511-32*gi -: 32];
`endif
        end
    endgenerate

    // Window positions relative to the word being emitted (win[0] = W[t]):
    // the word produced now becomes W[t+16], so it needs W[t+14], W[t+9],
    // W[t+1] and W[t] -> win[14], win[9], win[1], win[0].
    sha256_small_sigma #(
        .R1 (S0_R1),
        .R2 (S0_R2),
        .S  (S0_S)
    ) u_sigma0 (
        .x (win_reg[1]),
        .y (s0)
    );

    sha256_small_sigma #(
        .R1 (S1_R1),
        .R2 (S1_R2),
        .S  (S1_S)
    ) u_sigma1 (
        .x (win_reg[14]),
        .y (s1)
    );

    assign new_word = s1 + win_reg[9] + s0 + win_reg[0];

    assign blk_ready = (state_reg == IDLE);
    assign w_valid   = (state_reg == RUN);
    assign w_out     = win_reg[0];
    assign w_idx     = idx_reg;
    assign done      = done_reg;

    assign accept = blk_valid && blk_ready;
    assign step   = w_valid && w_ready;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            win_next[i] = win_reg[i];
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    for (int i = 0; i < 16; i++) begin
                        win_next[i] = load_word[i];
                    end
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (step) begin
                    for (int i = 0; i < 15; i++) begin
                        win_next[i] = win_reg[i+1];
                    end
                    win_next[15] = new_word;
                    if (idx_reg == LAST_IDX) begin
                        // Return idx to its idle value so w_idx reads 0
                        // between blocks regardless of ROUNDS.
                        idx_next   = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
            for (int i = 0; i < 16; i++) begin
                win_reg[i] <= win_next[i];
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// ----------------------------------------------------------------------------
// tb_sha256_msg_schedule
// Directed/randomized bench for sha256_msg_schedule with a word-array
// reference model of the FIPS 180-4 schedule recurrence.
// ----------------------------------------------------------------------------
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;
    localparam int IDX_W  = 6;
    localparam int BUDGET = 4 * ROUNDS + 16;

    logic             clk;
    logic             rst_n;
    logic             blk_valid;
    logic             blk_ready;
    logic [511:0]     block_in;
    logic             w_valid;
    logic             w_ready;
    logic [31:0]      w_out;
    logic [IDX_W-1:0] w_idx;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] blkw  [16];
    logic [31:0] expw  [ROUNDS];
    logic [31:0] obs_w [ROUNDS];

    sha256_msg_schedule #(
        .ROUNDS (ROUNDS),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .block_in  (block_in),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .w_idx     (w_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Whole-schedule reference: W[t] straight from the recurrence.
    task automatic build_model();
        for (int t = 0; t < ROUNDS; t++) begin
            if (t < 16) expw[t] = blkw[t];
            else        expw[t] = ref_s1(expw[t-2]) + expw[t-7] + ref_s0(expw[t-15]) + expw[t-16];
        end
    endtask

    // blkw holds the intended W[0..15]; in the byte-swap build the bus
    // carries the little-endian image so the DUT swaps it back.
    function automatic logic [511:0] pack_block();
        logic [511:0] b;
        logic [31:0]  w;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            w = blkw[i];
`ifdef SHA_SCHED_BYTESWAP_EN
            w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
            b[511-32*i -: 32] = w;
        end
        return b;
    endfunction

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blkw[i] = $urandom;
    endtask

    task automatic load_block();
        @(negedge clk);
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("load_ready", {31'd0, blk_ready}, 32'd1);
        block_in  = pack_block();
        blk_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Streams one block; toggle alternates w_ready, abort_at asserts reset
    // when that index is on the output, hold keeps blk_valid asserted.
    task automatic stream(input bit toggle, input int abort_at, input bit hold);
        int t   = 0;
        int cyc = 0;
        bit rdy;
        bit fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (!hold) blk_valid = 1'b0;
            chk("budget", {31'd0, cyc < BUDGET}, 32'd1);
            if (cyc >= BUDGET) return;
            chk($sformatf("w_valid[%0d]", t), {31'd0, w_valid}, 32'd1);
            chk($sformatf("w_idx[%0d]", t), 32'(w_idx), 32'(t));
            chk($sformatf("w_out[%0d]", t), w_out, expw[t]);
            chk("done_in_run", {31'd0, done}, 32'd0);
            chk("blk_ready_in_run", {31'd0, blk_ready}, 32'd0);
            if (t == abort_at) begin
                rst_n   = 1'b0;
                w_ready = 1'b0;
                #1;
                chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
                chk("rst_w_idx", 32'(w_idx), 32'd0);
                chk("rst_blk_ready", {31'd0, blk_ready}, 32'd1);
                chk("rst_w_out", w_out, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                @(negedge clk);
                chk("rst_done_hold", {31'd0, done}, 32'd0);
                rst_n = 1'b1;
                $display("txn abort at idx=%0d", t);
                return;
            end
            rdy     = toggle ? (cyc % 2 == 0) : 1'b1;
            w_ready = rdy;
            if (rdy) begin
                obs_w[t] = w_out;
                t++;
                if (t == ROUNDS) fin = 1'b1;
            end
            cyc++;
        end
        @(negedge clk);
        w_ready = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_w_valid", {31'd0, w_valid}, 32'd0);
        chk("done_blk_ready", {31'd0, blk_ready}, 32'd1);
        $display("txn block words=%0d cycles=%0d toggle=%0d", t, cyc, toggle);
    endtask

    task automatic abc_block();
        for (int i = 0; i < 16; i++) blkw[i] = 32'h0;
        blkw[0]  = 32'h61626380;
        blkw[15] = 32'h00000018;
    endtask

    task automatic check_abc_consts();
        chk("abc_W0",  obs_w[0],  32'h61626380);
        chk("abc_W15", obs_w[15], 32'h00000018);
        chk("abc_W16", obs_w[16], 32'h61626380);
        chk("abc_W17", obs_w[17], 32'h000F0000);
        chk("abc_W18", obs_w[18], 32'h7DA86405);
    endtask

    initial begin
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        w_ready   = 1'b0;
        block_in  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_blk_ready", {31'd0, blk_ready}, 32'd1);
        chk("reset_w_valid", {31'd0, w_valid}, 32'd0);
        chk("reset_w_out", w_out, 32'd0);
        chk("reset_w_idx", 32'(w_idx), 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // 1: "abc" block, w_ready held high
        abc_block();
        build_model();
        load_block();
        stream(1'b0, -1, 1'b0);
        check_abc_consts();

        // 2: same block, w_ready toggling
        for (int i = 0; i < ROUNDS; i++) obs_w[i] = 32'hDEADBEEF;
        load_block();
        stream(1'b1, -1, 1'b0);
        check_abc_consts();

        // 3: back-to-back with blk_valid held high
        rand_block();
        build_model();
        load_block();
        rand_block();
        block_in = pack_block();
        stream(1'b0, -1, 1'b1);
        build_model();
        stream(1'b0, -1, 1'b0);

        // 4: reset mid-block, then restart
        rand_block();
        build_model();
        load_block();
        stream(1'b0, 20, 1'b0);
        rand_block();
        build_model();
        load_block();
        stream(1'b1, -1, 1'b0);

        // 5: all-ones block exercises carry discard
        for (int i = 0; i < 16; i++) blkw[i] = 32'hFFFFFFFF;
        build_model();
        load_block();
        stream(1'b0, -1, 1'b0);
        chk("ones_W16", obs_w[16], 32'h203FFFFC);

        // 6: a few random blocks with random stall pattern
        for (int b = 0; b < 3; b++) begin
            rand_block();
            build_model();
            load_block();
            stream(b[0], -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
